// File: rtl/apb_bridge_arbiter_if.sv
// Purpose: requester-side req/gnt bundle plus AHB-lite master signals toward the APB bridge.
// Ports: master modport = arbiter view (drives grants, completions, AHB address/data);
//        slave modport  = environment view (requesters and bridge).
interface apb_bridge_arbiter_if #(
  parameter int NUM_MST = 3
);
  // Requester side
  logic [NUM_MST-1:0]    m_req;
  logic [NUM_MST-1:0]    m_we;
  logic [NUM_MST*32-1:0] m_addr;
  logic [NUM_MST*32-1:0] m_wdata;
  logic [NUM_MST-1:0]    m_gnt;
  logic [NUM_MST-1:0]    m_rvalid;
  logic [NUM_MST-1:0]    m_err;
  logic [31:0]           m_rdata;
  // AHB-lite side toward the bridge
  logic                  hsel;
  logic [31:0]           haddr;
  logic                  hwrite;
  logic [31:0]           hwdata;
  logic                  hready;
  logic [31:0]           hrdata;
  logic                  hresp;

  modport master (
    input  m_req, m_we, m_addr, m_wdata, hready, hrdata, hresp,
    output m_gnt, m_rvalid, m_err, m_rdata, hsel, haddr, hwrite, hwdata
  );

  modport slave (
    output m_req, m_we, m_addr, m_wdata, hready, hrdata, hresp,
    input  m_gnt, m_rvalid, m_err, m_rdata, hsel, haddr, hwrite, hwdata
  );
endinterface

// File: rtl/apb_bridge_arbiter.sv
// Purpose: round-robin share of the APB bridge AHB-lite slave port among NUM_MST req/gnt requesters.
// Latency: hsel 1 cycle after request, m_gnt 1 cycle after address accept, m_rvalid 1 cycle after data-phase hready.
// Backpressure: hready low stretches ADDR/DATA; pending requests wait in IDLE; watchdog aborts a stuck data phase.
// Ports: clk, rstn (async active-low); bus = apb_bridge_arbiter_if.master (requester and AHB-lite signals).
module apb_bridge_arbiter #(
  parameter int NUM_MST = 3,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic                 clk,
  input  logic                 rstn,
  apb_bridge_arbiter_if.master bus
);

  localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [TW-1:0]        wdog_q, wdog_d;

  logic                 hsel_q, hsel_d;
  logic [31:0]          haddr_q, haddr_d;
  logic                 hwrite_q, hwrite_d;
  logic [31:0]          hwdata_q, hwdata_d;
  logic [NUM_MST-1:0]   gnt_q, gnt_d;
  logic [NUM_MST-1:0]   rvalid_q, rvalid_d;
  logic [NUM_MST-1:0]   err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;

  // Round-robin pick: search begins just after the last winner and wraps.
  logic                 found;
  logic [IW-1:0]        win;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_MST; k++) begin
      if (!found && bus.m_req[(int'(rr_q) + k) % NUM_MST]) begin
        found = 1'b1;
        win   = IW'((int'(rr_q) + k) % NUM_MST);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wdog_d   = wdog_q;
    hsel_d   = hsel_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    gnt_d    = '0;
    rvalid_d = '0;
    err_d    = '0;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        hsel_d = 1'b0;
        if (found) begin
          owner_d  = win;
          rr_d     = win;
          we_d     = bus.m_we[win];
          wdata_d  = bus.m_wdata[32*win +: 32];
          haddr_d  = bus.m_addr[32*win +: 32];
          hwrite_d = bus.m_we[win];
          hsel_d   = 1'b1;
          state_d  = ADDR;
        end
      end

      ADDR: begin
        if (bus.hready) begin
          gnt_d[owner_q] = 1'b1;
          hsel_d         = 1'b0;
          hwdata_d       = wdata_q;
          wdog_d         = '0;
          state_d        = DATA;
        end
      end

      DATA: begin
        wdog_d = wdog_q + 1'b1;
        // wdog_q is zero only in the first data cycle, where the bridge's
        // registered hready still reflects the address phase.
        if ((wdog_q != '0) && bus.hready) begin
          rvalid_d[owner_q] = 1'b1;
          err_d[owner_q]    = bus.hresp;
          rdata_d           = we_q ? 32'h0 : bus.hrdata;
          state_d           = IDLE;
        end else if (wdog_q == TW'(TIMEOUT - 1)) begin
          rvalid_d[owner_q] = 1'b1;
          err_d[owner_q]    = 1'b1;
          rdata_d           = 32'h0;
          state_d           = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_q     <= IW'(NUM_MST - 1);
      owner_q  <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wdog_q   <= '0;
      hsel_q   <= 1'b0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wdog_q   <= wdog_d;
      hsel_q   <= hsel_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.hsel     = hsel_q;
  assign bus.haddr    = haddr_q;
  assign bus.hwrite   = hwrite_q;
  assign bus.hwdata   = hwdata_q;
  assign bus.m_gnt    = gnt_q;
  assign bus.m_rvalid = rvalid_q;
  assign bus.m_err    = err_q;
  assign bus.m_rdata  = rdata_q;

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Purpose: directed bench for apb_bridge_arbiter with a reactive bridge model and a completion scoreboard.
// Latency: checks grant/completion cycle counts relative to the request cycle.
// Backpressure: exercises hready stalls in address and data phase, watchdog abort and reset mid-transfer.
module tb_apb_bridge_arbiter;
  localparam int NM = 3;
  localparam int TO = 8;
  localparam int TW = 7;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  apb_bridge_arbiter_if #(.NUM_MST(NM)) bus ();

  apb_bridge_arbiter #(.NUM_MST(NM), .TIMEOUT(TO), .TW(TW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_rv = 0;
  int   last_gnt_cyc = 0;
  int   last_rv_cyc = 0;
  int   req_left[NM];

  // Bridge model state
  bit          auto_br = 1'b1;
  bit          br_hang = 1'b0;
  bit          br_resp_next = 1'b0;
  bit          br_acc = 1'b0;
  int          br_cnt = 0;
  logic [31:0] br_addr = '0;
  logic        br_wr = 1'b0;

  // Peripheral read contents as seen through the bridge.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h4001_1000) ? 32'h1234_5678 : (a ^ 32'hDEAD_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Bridge: ready when idle; after an accepted address, hready is low in the
  // first data cycle, then stays low 1 more cycle for writes (read completes in
  // the second data cycle). br_hang keeps it low forever.
  task automatic bridge_step();
    if (auto_br) begin
      if (br_acc) begin
        br_acc     = 1'b0;
        bus.hready = 1'b0;
        bus.hresp  = 1'b0;
        br_cnt     = br_hang ? 0 : (br_wr ? 2 : 1);
      end else if (br_cnt > 0) begin
        br_cnt--;
        if (br_cnt == 0) begin
          bus.hready = 1'b1;
          bus.hrdata = rd_fn(br_addr);
          bus.hresp  = br_resp_next;
        end
      end
      if (bus.hsel === 1'b1 && bus.hready === 1'b1) begin
        br_acc  = 1'b1;
        br_addr = bus.haddr;
        br_wr   = bus.hwrite;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    chk("gnt_onehot", 32'($onehot0(bus.m_gnt)), 32'd1);
    chk("rv_onehot", 32'($onehot0(bus.m_rvalid)), 32'd1);
    for (int i = 0; i < NM; i++) begin
      if (bus.m_gnt[i]) begin
        gnt_log.push_back(i);
        last_gnt_cyc = cyc;
        if (req_left[i] > 0) begin
          req_left[i]--;
          if (req_left[i] == 0) bus.m_req[i] = 1'b0;
        end
      end
    end
    if (bus.m_rvalid != '0) begin
      n_rv++;
      last_rv_cyc = cyc;
      if (sb.size() == 0) begin
        chk("stray_rvalid", 32'(bus.m_rvalid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rv_owner", 32'(bus.m_rvalid), 32'd1 << e.idx);
        chk("rv_err", 32'(bus.m_err), e.err ? (32'd1 << e.idx) : 32'd0);
        chk("rv_rdata", bus.m_rdata, e.rdata);
      end
    end
  endtask

  task automatic tick();
    bridge_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic do_req(input int i, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int n);
    bus.m_we[i]              = we;
    bus.m_addr[32*i +: 32]   = addr;
    bus.m_wdata[32*i +: 32]  = wdata;
    bus.m_req[i]             = 1'b1;
    req_left[i]              = n;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while ((sb.size() != 0 || bus.m_req != '0) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(k < budget), 32'd1);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hsel"},   32'(bus.hsel), 32'd0);
    chk({tag, "_haddr"},  bus.haddr, 32'd0);
    chk({tag, "_hwrite"}, 32'(bus.hwrite), 32'd0);
    chk({tag, "_hwdata"}, bus.hwdata, 32'd0);
    chk({tag, "_gnt"},    32'(bus.m_gnt), 32'd0);
    chk({tag, "_rvalid"}, 32'(bus.m_rvalid), 32'd0);
    chk({tag, "_err"},    32'(bus.m_err), 32'd0);
    chk({tag, "_rdata"},  bus.m_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed cycle %0d, expected finish", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int t0;
    int rv_before;
    logic [31:0] a;

    for (int i = 0; i < NM; i++) req_left[i] = 0;
    bus.m_req   = '0;
    bus.m_we    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.hready  = 1'b1;
    bus.hrdata  = '0;
    bus.hresp   = 1'b0;

    // Reset values
    repeat (2) tick();
    chk_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Single write from m0
    sb.push_back('{0, 1'b0, 32'h0});
    t0 = cyc;
    do_req(0, 1'b1, 32'h4001_0004, 32'hA5A5_0001, 1);
    tick();
    chk("wr_hsel_c1", 32'(bus.hsel), 32'd1);
    chk("wr_haddr", bus.haddr, 32'h4001_0004);
    chk("wr_hwrite", 32'(bus.hwrite), 32'd1);
    tick();
    chk("wr_hsel_c2", 32'(bus.hsel), 32'd0);
    chk("wr_hwdata", bus.hwdata, 32'hA5A5_0001);
    chk("wr_gnt", 32'(bus.m_gnt), 32'd1);
    wait_done("wr_done", 50);
    chk("wr_gnt_lat", 32'(last_gnt_cyc - t0), 32'd2);
    chk("wr_rv_lat", 32'(last_rv_cyc - t0), 32'd5);

    // Single read from m1
    sb.push_back('{1, 1'b0, 32'h1234_5678});
    t0 = cyc;
    do_req(1, 1'b0, 32'h4001_1000, 32'h0, 1);
    wait_done("rd_done", 50);
    chk("rd_gnt_lat", 32'(last_gnt_cyc - t0), 32'd2);
    chk("rd_rv_lat", 32'(last_rv_cyc - t0), 32'd4);

    // Contention from reset: order 0,1,2,0,1,2
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    gnt_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NM; i++)
        sb.push_back('{i, 1'b0, rd_fn(32'h4002_0000 + 32'(16 * i))});
    for (int i = 0; i < NM; i++) do_req(i, 1'b0, 32'h4002_0000 + 32'(16 * i), 32'h0, 2);
    wait_done("cont_done", 200);
    chk("cont_ngnt", 32'(gnt_log.size()), 32'd6);
    for (int k = 0; k < gnt_log.size() && k < 6; k++)
      chk("cont_order", 32'(gnt_log[k]), 32'(k % NM));

    // hready low during address phase
    auto_br = 1'b0;
    bus.hready = 1'b0;
    sb.push_back('{2, 1'b0, 32'h0});
    do_req(2, 1'b1, 32'h4003_0008, 32'h0BAD_F00D, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hsel", 32'(bus.hsel), 32'd1);
      chk("stall_haddr", bus.haddr, 32'h4003_0008);
      chk("stall_hwrite", 32'(bus.hwrite), 32'd1);
      chk("stall_nogrant", 32'(bus.m_gnt), 32'd0);
    end
    bus.hready = 1'b1;
    auto_br = 1'b1;
    tick();
    chk("stall_gnt", 32'(bus.m_gnt), 32'b100);
    chk("stall_hwdata", bus.hwdata, 32'h0BAD_F00D);
    wait_done("stall_done", 50);

    // Watchdog abort
    br_hang = 1'b1;
    sb.push_back('{0, 1'b1, 32'h0});
    do_req(0, 1'b0, 32'h4004_0000, 32'h0, 1);
    wait_done("to_done", 60);
    chk("to_lat", 32'(last_rv_cyc - last_gnt_cyc), 32'(TO));
    br_hang = 1'b0;
    bus.hready = 1'b1;   // late hready after abort, must be ignored
    bus.hrdata = 32'hFFFF_FFFF;
    repeat (2) tick();
    sb.push_back('{1, 1'b0, 32'h1234_5678});
    t0 = cyc;
    do_req(1, 1'b0, 32'h4001_1000, 32'h0, 1);
    wait_done("post_to_done", 50);
    chk("post_to_lat", 32'(last_rv_cyc - t0), 32'd4);

    // Error response
    br_resp_next = 1'b1;
    a = 32'h4005_0000;
    sb.push_back('{2, 1'b1, rd_fn(a)});
    do_req(2, 1'b0, a, 32'h0, 1);
    wait_done("err_done", 50);
    br_resp_next = 1'b0;

    // Reset during the data phase
    br_hang = 1'b1;
    do_req(0, 1'b1, 32'h4006_0000, 32'h1111_2222, 1);
    repeat (3) tick();
    chk("mid_in_data_hwdata", bus.hwdata, 32'h1111_2222);
    rstn = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    rv_before = n_rv;
    bus.m_req = '0;
    for (int i = 0; i < NM; i++) req_left[i] = 0;
    br_hang = 1'b0;
    br_acc = 1'b0;
    br_cnt = 0;
    bus.hready = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (10) tick();
    chk("no_stray_rv", 32'(n_rv), 32'(rv_before));
    a = 32'h4007_0010;
    sb.push_back('{2, 1'b0, rd_fn(a)});
    t0 = cyc;
    do_req(2, 1'b0, a, 32'h0, 1);
    wait_done("after_rst_done", 50);
    chk("after_rst_gnt_lat", 32'(last_gnt_cyc - t0), 32'd2);
    chk("after_rst_rv_lat", 32'(last_rv_cyc - t0), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
